matrix_bram_loader: RTL and testbench

- Writer-side counterpart to the systolic top's input-memory read port.
- Accepts a stream of matrix elements over a valid/ready handshake: weight (top) matrix first, then input (left) matrix, each row-major.
- Packs elements into MEM_PORT_WIDTH words and writes them to the input bram_mat at consecutive addresses.
- Once both matrices are resident, raises inputs_rdy to bisr_systolic_top and holds it until the top acknowledges consumption.

---
 rtl/matrix_bram_loader_pkg.sv | 33 +++
 rtl/matrix_bram_loader_word_packer.sv | 99 +++++++++
 rtl/matrix_bram_loader.sv | 182 ++++++++++++++++++
 tb/tb_matrix_bram_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_bram_loader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_bram_loader_pkg
// Shared definitions for the matrix BRAM loader and anything that needs to
// decode its behaviour (benches, neighbouring blocks).
//   LANES / TOTAL / BEATS : geometry for the default 4x4, 8-bit, 32-bit port
//   loader_state_e        : loader FSM state encoding
//   ceil_div()            : integer ceiling division used for beat counts
// Optional feature macro handled by the loader: LOADER_LEN_CHECK_EN
// ---------------------------------------------------------------------------
package matrix_bram_loader_pkg;

  localparam int DEFAULT_ROWS      = 4;
  localparam int DEFAULT_COLS      = 4;
  localparam int DEFAULT_WORD_SIZE = 8;
  localparam int DEFAULT_MEM_WIDTH = 32;

  // Elements per BRAM word, elements per full load, BRAM words per load.
  localparam int LANES = DEFAULT_MEM_WIDTH / DEFAULT_WORD_SIZE;
  localparam int TOTAL = 2 * DEFAULT_ROWS * DEFAULT_COLS;
  localparam int BEATS = (TOTAL + LANES - 1) / LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_READY = 2'd3
  } loader_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/matrix_bram_loader_word_packer.sv
// ---------------------------------------------------------------------------
// matrix_bram_loader_word_packer
// Accumulates WORD_SIZE elements into MEM_PORT_WIDTH words and issues one
// registered BRAM write per completed (or flushed) word.
//   clk, rst        : clock, async active-high reset
//   clear           : restart packing, rewind address to BASE_ADDR
//   push/push_data  : one element into the next free lane
//   flush           : write out a partially filled word (upper lanes zero)
//   pending         : at least one lane of the current word is filled
//   mem_wr_en/mem_wr_data/mem_addr : registered BRAM write port
// ---------------------------------------------------------------------------
module matrix_bram_loader_word_packer #(
  parameter int          WORD_SIZE      = 8,
  parameter int          MEM_PORT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic [WORD_SIZE-1:0]      push_data,
  input  logic                      flush,
  output logic                      pending,
  output logic                      mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
  output logic [31:0]               mem_addr
);

  localparam int NUM_LANES = MEM_PORT_WIDTH / WORD_SIZE;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [MEM_PORT_WIDTH-1:0] acc_q, acc_d;
  logic                      wr_en_q, wr_en_d;
  logic [MEM_PORT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]               addr_q, addr_d;
  logic [MEM_PORT_WIDTH-1:0] merged;
  logic                      last_lane;

  assign last_lane   = (lane_q == LANE_W'(NUM_LANES - 1));
  assign pending     = (lane_q != '0);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign mem_addr    = addr_q;

  // The accumulator and the write register are separate, so the word being
  // written never blocks the next element: that is the double buffer that
  // lets s_ready stay high through the write cycle. The accumulator is
  // zeroed after every word, which is what zero-fills flushed upper lanes.
  always_comb begin
    merged = acc_q;
    merged[lane_q*WORD_SIZE +: WORD_SIZE] = push_data;

    lane_d    = lane_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    // The address advances only after the cycle that presented the write.
    addr_d    = wr_en_q ? (addr_q + 32'd1) : addr_q;

    if (clear) begin
      lane_d = '0;
      acc_d  = '0;
      addr_d = BASE_ADDR;
    end else if (push) begin
      if (last_lane) begin
        wr_en_d   = 1'b1;
        wr_data_d = merged;
        acc_d     = '0;
        lane_d    = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + LANE_W'(1);
      end
    end else if (flush && pending) begin
      wr_en_d   = 1'b1;
      wr_data_d = acc_q;
      acc_d     = '0;
      lane_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= BASE_ADDR;
    end else begin
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: rtl/matrix_bram_loader.sv
// ---------------------------------------------------------------------------
// matrix_bram_loader
// Streams the weight (top) matrix then the input (left) matrix, row-major,
// into the systolic top's input BRAM, packed LANES elements per word at
// consecutive addresses from BASE_ADDR, then raises inputs_rdy until
// matmul_ack.
//   clk, rst                 : clock, async active-high reset
//   load_start               : start a load (only honoured in IDLE)
//   s_valid/s_data/s_ready   : element stream handshake
//   mem_addr/mem_wr_en/mem_wr_data : BRAM write port
//   inputs_rdy / matmul_ack  : hand-off to the systolic top
//   busy                     : high whenever not IDLE
// Optional: define LOADER_LEN_CHECK_EN to add s_last (in) and len_err (out).
// An early s_last zero-pads the rest of the load; a missing s_last on the
// final element is also flagged. len_err is sticky until the next load.
// ---------------------------------------------------------------------------
module matrix_bram_loader
  import matrix_bram_loader_pkg::*;
#(
  parameter int          ROWS           = 4,
  parameter int          COLS           = 4,
  parameter int          WORD_SIZE      = 8,
  parameter int          MEM_PORT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      s_valid,
  input  logic [WORD_SIZE-1:0]      s_data,
  output logic                      s_ready,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
  output logic                      inputs_rdy,
  input  logic                      matmul_ack,
  output logic                      busy
`ifdef LOADER_LEN_CHECK_EN
  ,
  input  logic                      s_last,
  output logic                      len_err
`endif
);

  localparam int NUM_ELEMS = 2 * ROWS * COLS;
  localparam int CNT_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  loader_state_e        state_q, state_d;
  logic [CNT_W-1:0]     elem_cnt_q, elem_cnt_d;
  logic                 last_elem;
  logic                 accept;
  logic                 pk_clear;
  logic                 pk_push;
  logic [WORD_SIZE-1:0] pk_data;
  logic                 pk_flush;
  logic                 pk_pending;

`ifdef LOADER_LEN_CHECK_EN
  logic pad_q, pad_d;
  logic len_err_q, len_err_d;
  assign len_err = len_err_q;
`endif

  assign last_elem = (elem_cnt_q == CNT_W'(NUM_ELEMS - 1));

  matrix_bram_loader_word_packer #(
    .WORD_SIZE      (WORD_SIZE),
    .MEM_PORT_WIDTH (MEM_PORT_WIDTH),
    .BASE_ADDR      (BASE_ADDR)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pk_clear),
    .push        (pk_push),
    .push_data   (pk_data),
    .flush       (pk_flush),
    .pending     (pk_pending),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_addr    (mem_addr)
  );

  // Next-state and handshake decode. FLUSH leaves only once no lanes are
  // pending and the final word is on the write port, so READY never
  // precedes the last BRAM write.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    s_ready    = 1'b0;
    inputs_rdy = 1'b0;
    busy       = (state_q != ST_IDLE);
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    pk_data    = s_data;
    pk_flush   = 1'b0;
    accept     = 1'b0;
`ifdef LOADER_LEN_CHECK_EN
    pad_d      = pad_q;
    len_err_d  = len_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_FILL;
          elem_cnt_d = '0;
          pk_clear   = 1'b1;
`ifdef LOADER_LEN_CHECK_EN
          pad_d      = 1'b0;
          len_err_d  = 1'b0;
`endif
        end
      end

      ST_FILL: begin
`ifdef LOADER_LEN_CHECK_EN
        // While padding after an early s_last the stream is closed and a
        // zero element is pushed every cycle until the count completes.
        s_ready = !pad_q;
        if (pad_q) begin
          accept  = 1'b1;
          pk_data = '0;
        end else if (s_valid) begin
          accept = 1'b1;
          if (s_last && !last_elem) begin
            pad_d     = 1'b1;
            len_err_d = 1'b1;
          end
          if (!s_last && last_elem) begin
            len_err_d = 1'b1;
          end
        end
`else
        s_ready = 1'b1;
        accept  = s_valid;
`endif
        if (accept) begin
          pk_push    = 1'b1;
          elem_cnt_d = elem_cnt_q + CNT_W'(1);
          if (last_elem) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        pk_flush = pk_pending;
        if (!pk_pending && mem_wr_en) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        inputs_rdy = 1'b1;
        if (matmul_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      elem_cnt_q <= '0;
`ifdef LOADER_LEN_CHECK_EN
      pad_q      <= 1'b0;
      len_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
`ifdef LOADER_LEN_CHECK_EN
      pad_q      <= pad_d;
      len_err_q  <= len_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_bram_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_bram_loader
// Directed sequence with randomized data/valid against two loaders: the
// default 4x4 geometry (a_*) and a 3x3 geometry (b_*) that ends on a
// partial word. Expected BRAM contents come from the element-to-address
// rule: element k lands at address k/LANES, lane k%LANES.
// ---------------------------------------------------------------------------
module tb_matrix_bram_loader;
  import matrix_bram_loader_pkg::*;

  localparam int B_TOTAL = 18;
  localparam int B_BEATS = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_load_start, a_s_valid, a_s_ready, a_mem_wr_en, a_inputs_rdy, a_matmul_ack, a_busy;
  logic [7:0]  a_s_data;
  logic [31:0] a_mem_addr, a_mem_wr_data;
  logic        b_load_start, b_s_valid, b_s_ready, b_mem_wr_en, b_inputs_rdy, b_matmul_ack, b_busy;
  logic [7:0]  b_s_data;
  logic [31:0] b_mem_addr, b_mem_wr_data;
`ifdef LOADER_LEN_CHECK_EN
  logic a_s_last, a_len_err, b_s_last, b_len_err;
`endif

  matrix_bram_loader dut_a (
    .clk(clk), .rst(rst), .load_start(a_load_start), .s_valid(a_s_valid),
    .s_data(a_s_data), .s_ready(a_s_ready), .mem_addr(a_mem_addr),
    .mem_wr_en(a_mem_wr_en), .mem_wr_data(a_mem_wr_data),
    .inputs_rdy(a_inputs_rdy), .matmul_ack(a_matmul_ack), .busy(a_busy)
`ifdef LOADER_LEN_CHECK_EN
    , .s_last(a_s_last), .len_err(a_len_err)
`endif
  );

  matrix_bram_loader #(.ROWS(3), .COLS(3)) dut_b (
    .clk(clk), .rst(rst), .load_start(b_load_start), .s_valid(b_s_valid),
    .s_data(b_s_data), .s_ready(b_s_ready), .mem_addr(b_mem_addr),
    .mem_wr_en(b_mem_wr_en), .mem_wr_data(b_mem_wr_data),
    .inputs_rdy(b_inputs_rdy), .matmul_ack(b_matmul_ack), .busy(b_busy)
`ifdef LOADER_LEN_CHECK_EN
    , .s_last(b_s_last), .len_err(b_len_err)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned wcyc;
  } wr_t;

  wr_t        wq_a[$];
  wr_t        wq_b[$];
  logic [7:0] elem_vals[64];
  int         hs_cyc[64];
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;

  // Write monitors: capture every BRAM write with the cycle it appeared in.
  always @(negedge clk) begin
    wr_t w;
    if (a_mem_wr_en === 1'b1) begin
      w.addr = a_mem_addr; w.data = a_mem_wr_data; w.wcyc = cyc;
      wq_a.push_back(w);
    end
    if (b_mem_wr_en === 1'b1) begin
      w.addr = b_mem_addr; w.data = b_mem_wr_data; w.wcyc = cyc;
      wq_b.push_back(w);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference word: element k sits at address k/LANES, lane k%LANES;
  // elements at or beyond n_real read as zero.
  function automatic logic [31:0] expWord(input int j, input int n_real);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      int k;
      k = j * LANES + l;
      if (k < n_real) w[l*8 +: 8] = elem_vals[k];
    end
    return w;
  endfunction

  // Drive elements 0..n-1; s_last marks index last_idx. Handshake cycles
  // are recorded so write latency can be checked.
  task automatic applyStimulus(input bit sel, input int n, input bit rand_valid,
                               input int last_idx);
    int   idx;
    int   budget;
    logic v;
    logic rdy;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 3000) begin
      @(negedge clk);
      budget++;
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) begin
        b_s_valid = v; b_s_data = elem_vals[idx]; rdy = b_s_ready;
`ifdef LOADER_LEN_CHECK_EN
        b_s_last = (idx == last_idx);
`endif
      end else begin
        a_s_valid = v; a_s_data = elem_vals[idx]; rdy = a_s_ready;
`ifdef LOADER_LEN_CHECK_EN
        a_s_last = (idx == last_idx);
`endif
      end
      if (v && rdy) begin
        hs_cyc[idx] = int'(cyc);
        idx++;
      end
    end
    checkOutput("handshake_count", 64'(idx), 64'(n));
    @(negedge clk);
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
`ifdef LOADER_LEN_CHECK_EN
    a_s_last = 1'b0;
    b_s_last = 1'b0;
`endif
    if (last_idx < 0) begin end
  endtask

  task automatic checkWrites(input bit sel, input int n_real, input int beats);
    wr_t q[$];
    if (sel) q = wq_b; else q = wq_a;
    checkOutput("write_count", 64'(q.size()), 64'(beats));
    for (int j = 0; j < beats && j < q.size(); j++) begin
      checkOutput($sformatf("wr%0d_addr", j), 64'(q[j].addr), 64'(j));
      checkOutput($sformatf("wr%0d_data", j), 64'(q[j].data), 64'(expWord(j, n_real)));
      if (j * LANES + LANES - 1 < n_real)
        checkOutput($sformatf("wr%0d_latency", j), 64'(q[j].wcyc),
                    64'(hs_cyc[j*LANES+LANES-1] + 1));
    end
  endtask

  task automatic waitReady(input bit sel);
    int t;
    t = 0;
    while (((sel ? b_inputs_rdy : a_inputs_rdy) !== 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput(sel ? "b_ready_wait" : "a_ready_wait",
                64'(sel ? b_inputs_rdy : a_inputs_rdy), 64'd1);
  endtask

  task automatic pulseLoad(input bit sel);
    @(negedge clk);
    if (sel) b_load_start = 1'b1; else a_load_start = 1'b1;
    @(negedge clk);
    a_load_start = 1'b0;
    b_load_start = 1'b0;
  endtask

  task automatic pulseAck(input bit sel);
    @(negedge clk);
    if (sel) b_matmul_ack = 1'b1; else a_matmul_ack = 1'b1;
    @(negedge clk);
    a_matmul_ack = 1'b0;
    b_matmul_ack = 1'b0;
  endtask

  initial begin
    int sz;
    rst = 1'b1;
    a_load_start = 0; a_s_valid = 0; a_s_data = 0; a_matmul_ack = 0;
    b_load_start = 0; b_s_valid = 0; b_s_data = 0; b_matmul_ack = 0;
`ifdef LOADER_LEN_CHECK_EN
    a_s_last = 0; b_s_last = 0;
`endif
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_s_ready", 64'(a_s_ready), 64'd0);
    checkOutput("rst_wr_en", 64'(a_mem_wr_en), 64'd0);
    checkOutput("rst_inputs_rdy", 64'(a_inputs_rdy), 64'd0);
    checkOutput("rst_busy", 64'(a_busy), 64'd0);
    checkOutput("rst_addr", 64'(a_mem_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(a_mem_wr_data), 64'd0);
    rst = 1'b0;

    $display("[TB] back-to-back load of 1..32");
    for (int i = 0; i < 64; i++) elem_vals[i] = 8'(i + 1);
    wq_a.delete();
    pulseLoad(0);
    checkOutput("fill_s_ready", 64'(a_s_ready), 64'd1);
    checkOutput("fill_busy", 64'(a_busy), 64'd1);
    applyStimulus(0, TOTAL, 0, TOTAL - 1);
    checkOutput("rdy_after_1", 64'(a_inputs_rdy), 64'd0);
    @(negedge clk);
    checkOutput("rdy_after_2", 64'(a_inputs_rdy), 64'd1);
    checkWrites(0, TOTAL, BEATS);
    checkOutput("addr0_word", 64'(wq_a.size() > 0 ? wq_a[0].data : 32'hx), 64'h04030201);
`ifdef LOADER_LEN_CHECK_EN
    checkOutput("len_err_clean", 64'(a_len_err), 64'd0);
`endif

    $display("[TB] load_start and stray input while READY");
    sz = wq_a.size();
    a_s_valid = 1'b1;
    pulseLoad(0);
    a_s_valid = 1'b0;
    checkOutput("ready_holds", 64'(a_inputs_rdy), 64'd1);
    checkOutput("ready_s_ready", 64'(a_s_ready), 64'd0);
    checkOutput("ready_no_write", 64'(wq_a.size()), 64'(sz));
    pulseAck(0);
    checkOutput("ack_rdy_drop", 64'(a_inputs_rdy), 64'd0);
    checkOutput("ack_busy", 64'(a_busy), 64'd0);

    $display("[TB] random-valid reload of 1..32");
    wq_a.delete();
    pulseLoad(0);
    checkOutput("reload_base_addr", 64'(a_mem_addr), 64'd0);
    applyStimulus(0, TOTAL, 1, TOTAL - 1);
    waitReady(0);
    checkWrites(0, TOTAL, BEATS);
    pulseAck(0);

    $display("[TB] 3x3 load ending on a partial word");
    for (int i = 0; i < 64; i++) elem_vals[i] = 8'($urandom);
    wq_b.delete();
    pulseLoad(1);
    applyStimulus(1, B_TOTAL, 1, B_TOTAL - 1);
    waitReady(1);
    checkWrites(1, B_TOTAL, B_BEATS);
    checkOutput("b_addr4_word", 64'(wq_b.size() > 4 ? wq_b[4].data : 32'hx),
                64'({16'd0, elem_vals[17], elem_vals[16]}));
    pulseAck(1);
    checkOutput("b_ack_busy", 64'(b_busy), 64'd0);

    $display("[TB] reset after element 10");
    wq_a.delete();
    pulseLoad(0);
    applyStimulus(0, 11, 0, -1);
    a_s_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_wr_en", 64'(a_mem_wr_en), 64'd0);
    checkOutput("midrst_s_ready", 64'(a_s_ready), 64'd0);
    checkOutput("midrst_busy", 64'(a_busy), 64'd0);
    checkOutput("midrst_addr", 64'(a_mem_addr), 64'd0);
    checkOutput("midrst_prior_writes", 64'(wq_a.size()), 64'd2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("postrst_writes", 64'(wq_a.size()), 64'd2);
    checkOutput("postrst_s_ready", 64'(a_s_ready), 64'd0);
    checkOutput("postrst_busy", 64'(a_busy), 64'd0);
    a_s_valid = 1'b0;

`ifdef LOADER_LEN_CHECK_EN
    $display("[TB] early s_last on element 20");
    for (int i = 0; i < 64; i++) elem_vals[i] = 8'($urandom_range(1, 255));
    wq_a.delete();
    pulseLoad(0);
    applyStimulus(0, 21, 0, 20);
    waitReady(0);
    checkWrites(0, 21, BEATS);
    checkOutput("len_err_set", 64'(a_len_err), 64'd1);
    pulseAck(0);
    checkOutput("len_err_sticky", 64'(a_len_err), 64'd1);
    pulseLoad(0);
    checkOutput("len_err_cleared", 64'(a_len_err), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
